optic_flow_color_fifo_ci: RTL
=============================

OPTIC_FLOW_COLOR_FIFO_CI -- requirements
Module: optic_flow_color_fifo_ci

Interface
REQ-001 SHALL have parameter customInstructionId, default 8'd30, custom-instruction number this block answers.
REQ-002 SHALL have parameter DEPTH, default 8, pixel-pair FIFO depth; power of two, >= 4.
REQ-003 SHALL have port clock  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start  input  1  instruction strobe, valid only when ciN == customInstructionId.
REQ-006 SHALL have port ciN  input  8  custom-instruction number.
REQ-007 SHALL have port valueA  input  32  operand A: codes or palette data.
REQ-008 SHALL have port valueB  input  32  operand B; valueB[2:0] selects the operation.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port result  output  32  result word; 0 whenever done is low.

Function
REQ-011 SHALL accept start only when ciN == customInstructionId and the state machine is IDLE; all other starts are ignored, with no done.
REQ-012 SHALL implement states IDLE, CONV, RESP: IDLE->CONV on LOAD, IDLE->RESP on any other accepted op, CONV->RESP after 4 conversion cycles, RESP->IDLE unconditionally.
REQ-013 SHALL register done and result; done is high exactly during RESP.
REQ-014 SHALL treat valueA as eight 4-bit flow codes; pair k (k = 0..3) = {palette[nibble 2k+1], palette[nibble 2k]} (high half = odd nibble).
REQ-015 SHALL hold a 16-entry x 16-bit RGB565 palette; default entry i = (i[1] ? 0x8000 : 0) | (i[0] ? 0x0400 : 0) | (i[2] ? 0x0010 : 0) | (i[3] ? 0x4208 : 0).
REQ-016 Op 0 LOAD: if free space >= 4, capture valueA at start and write pairs 0..3 on the four CONV edges, one per cycle; done 5 cycles after the start edge; result = occupancy after push.
REQ-017 LOAD with free space < 4: no write, no CONV; done next cycle; result = 0x8000_0000 | occupancy.
REQ-018 Op 1 POP: done next cycle; result = head pair, head removed; if empty, result = 0 and nothing changes.
REQ-019 Op 2 WRPAL: palette[valueA[19:16]] <= valueA[15:0]; done next cycle; result = 0.
REQ-020 Op 3 STATUS: done next cycle; result = {16'b0, occupancy}; full flag = occupancy == DEPTH.
REQ-021 Op 4 CLEAR: FIFO emptied; done next cycle; result = 0; palette unchanged.
REQ-022 Ops 5-7: done next cycle; result = 0; no state change.
REQ-023 Conversion SHALL use palette contents current at each CONV cycle.
REQ-024 FIFO read/write pointers SHALL wrap modulo DEPTH; occupancy is clog2(DEPTH)+1 bits wide and never exceeds DEPTH.
REQ-025 No overflow or underflow is possible; full and empty are handled per REQ-017 and REQ-018.

Reset
REQ-026 While reset == 0 at a rising edge: state = IDLE, done = 0, result = 0, FIFO empty, pointers = 0, palette = defaults.
REQ-027 Reset during CONV SHALL discard partially written pairs; no done is issued for the aborted LOAD.
REQ-028 start SHALL be ignored in any cycle where reset == 0.

Verification
REQ-029 Reset, then STATUS -> done one cycle later, result 0x0000_0000.
REQ-030 LOAD valueA = 0x0000_0021 -> done 5 cycles after the start edge, result 4; POP -> 0x8000_0400; three more POPs -> 0x0000_0000 each; fifth POP (empty) -> result 0, done 1.
REQ-031 WRPAL valueA = 0x000F_FFFF, then LOAD 0xFFFF_FFFF, then POP -> 0xFFFF_FFFF; LOAD 0x8888_8888 then POP -> 0x4208_4208.
REQ-032 DEPTH = 8: two LOADs -> results 4 then 8; third LOAD -> result 0x8000_0008 and STATUS stays 8; CLEAR then STATUS -> 0.
REQ-033 Assert reset two cycles into a LOAD -> no done; STATUS -> 0; LOAD 0x0000_0008, POP -> 0x0000_4208 (palette restored to defaults).
REQ-034 start with ciN = 47, or start while in CONV -> done stays 0, result stays 0, no FIFO or palette change.

Source files
------------

// File: rtl/optic_flow_color_fifo_ci_if.sv
// Custom-instruction bus between a processor (master) and the flow-colour FIFO (slave).
interface optic_flow_color_fifo_ci_if;
  logic        start;
  logic [7:0]  ciN;
  logic [31:0] valueA;
  logic [31:0] valueB;
  logic        done;
  logic [31:0] result;

  modport master (output start, ciN, valueA, valueB, input done, result);
  modport slave  (input start, ciN, valueA, valueB, output done, result);
endinterface

// File: rtl/optic_flow_color_fifo_ci.sv
// Optic-flow colour FIFO: converts 4-bit flow codes through a 16-entry RGB565 palette
// into pixel pairs queued in a FIFO, driven by a custom-instruction bus.
module optic_flow_color_fifo_ci #(
  parameter logic [7:0] customInstructionId = 8'd30,
  parameter int         DEPTH               = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  optic_flow_color_fifo_ci_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, CONV, RESP} state_t;

  state_t        state_reg;
  logic          done_reg;
  logic [31:0]   result_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [1:0]    conv_cnt_reg;
  logic [31:0]   codes_reg;
  logic [31:0]   mem [DEPTH];
  logic [15:0]   palette [16];

  logic       accept;
  logic [2:0] op;
  logic       room;
  logic       pal_we;
  logic [3:0] pal_idx;

  assign op      = bus.valueB[2:0];
  assign accept  = reset && bus.start && (bus.ciN == customInstructionId) && (state_reg == IDLE);
  assign room    = count_reg <= CW'(DEPTH - 4);
  assign pal_we  = accept && (op == 3'd2);
  assign pal_idx = bus.valueA[19:16];

  assign bus.done   = done_reg;
  assign bus.result = result_reg;

  function automatic logic [15:0] pal_default(input logic [3:0] i);
    return (i[1] ? 16'h8000 : 16'h0000) | (i[0] ? 16'h0400 : 16'h0000) |
           (i[2] ? 16'h0010 : 16'h0000) | (i[3] ? 16'h4208 : 16'h0000);
  endfunction

  // One register per palette entry so each can reset to its own default colour.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_pal
      logic [15:0] entry_reg;
      always_ff @(posedge clock) begin
        if (!reset)
          entry_reg <= pal_default(4'(gi));
        else if (pal_we && pal_idx == 4'(gi))
          entry_reg <= bus.valueA[15:0];
      end
      assign palette[gi] = entry_reg;
    end
  endgenerate

  // Pairs land ahead of the write pointer; the pointer only commits on the last
  // conversion cycle, so a reset mid-LOAD leaves nothing visible.
  always_ff @(posedge clock) begin
    if (reset && state_reg == CONV)
      mem[wr_ptr_reg + PW'(conv_cnt_reg)] <= {palette[codes_reg[7:4]], palette[codes_reg[3:0]]};
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg    <= IDLE;
      done_reg     <= 1'b0;
      result_reg   <= '0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      conv_cnt_reg <= '0;
      codes_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            state_reg  <= RESP;
            done_reg   <= 1'b1;
            result_reg <= '0;
            case (op)
              3'd0: begin
                if (room) begin
                  state_reg    <= CONV;
                  done_reg     <= 1'b0;
                  codes_reg    <= bus.valueA;
                  conv_cnt_reg <= '0;
                end else begin
                  result_reg <= 32'h8000_0000 | 32'(count_reg);
                end
              end
              3'd1: begin
                if (count_reg != '0) begin
                  result_reg <= mem[rd_ptr_reg];
                  rd_ptr_reg <= rd_ptr_reg + 1'b1;
                  count_reg  <= count_reg - 1'b1;
                end
              end
              3'd3: result_reg <= 32'(count_reg);
              3'd4: begin
                rd_ptr_reg <= '0;
                wr_ptr_reg <= '0;
                count_reg  <= '0;
              end
              default: result_reg <= '0;
            endcase
          end
        end
        CONV: begin
          codes_reg    <= codes_reg >> 8;
          conv_cnt_reg <= conv_cnt_reg + 1'b1;
          if (conv_cnt_reg == 2'd3) begin
            wr_ptr_reg <= wr_ptr_reg + PW'(4);
            count_reg  <= count_reg + CW'(4);
            result_reg <= 32'(count_reg + CW'(4));
            done_reg   <= 1'b1;
            state_reg  <= RESP;
          end
        end
        RESP: begin
          done_reg   <= 1'b0;
          result_reg <= '0;
          state_reg  <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule
